// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory arbiter slice.
//   IM_DEPTH   : default number of 32-bit words in the instruction memory
//   IM_IDX_W   : word-index width at the default depth
//   im_state_e : arbiter FSM state (LOAD after reset, RUN once the program is in)
//   im_idx()   : byte address -> word address (addr[31:2]); callers keep the
//                low log2(depth) bits as the memory index
package im_pkg;

  localparam int IM_DEPTH = 64;
  localparam int IM_IDX_W = $clog2(IM_DEPTH);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } im_state_e;

  function automatic logic [29:0] im_idx(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/im_ram.sv
// Single-port DEPTH x 32 instruction storage, no reset.
//   clk_i   : clock, rising edge
//   we_i    : write idx_i with wdata_i at this edge
//   re_i    : latch the word at idx_i into rdata_o at this edge
//   idx_i   : word index shared by the read and write paths
//   wdata_i : write data
//   rdata_o : registered read data; holds its value when re_i is low
module im_ram #(
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/im_arbiter.sv
// Owns the single-port instruction memory and shares it between the fetch
// stage (reads) and the program loader (writes). Fetch is held off after
// reset until the loader reports the program is in place; afterwards the
// loader has priority, but fetch is forced through after STARVE_MAX
// consecutive denied cycles.
//
// Handshake (both requesters): a transfer happens at the rising edge where
// req & gnt; the requester holds address/data until granted, and gnt is never
// raised without req. Grants are combinational; read data arrives registered
// one cycle after the grant edge, flagged by f_rvalid.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   f_req/f_addr        : fetch read request, byte address
//   f_gnt               : fetch granted this cycle
//   f_rvalid/f_rdata    : registered read response
//   f_err               : bad fetch address, qualified by f_rvalid
//   l_req/l_addr/l_wdata: loader write request, byte address, data
//   l_gnt/l_err         : loader grant, bad loader address (same cycle)
//   l_done              : loader finished; moves LOAD -> RUN
//   running             : high in RUN
//   dbg_state           : current FSM state
//
// Build option: define IM_ARB_BOUNDS_EN to reject misaligned or out-of-range
// addresses (bad reads return 0 with f_err, bad writes are dropped with
// l_err). Without it addresses wrap modulo DEPTH and both error flags are 0.
module im_arbiter
  import im_pkg::*;
#(
  parameter int DEPTH      = IM_DEPTH,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        l_req,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_err,
  input  logic        l_done,
  output logic        running,
  output im_state_e   dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  im_state_e        state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             f_rvalid_q;
  logic             f_err_q;
  logic             rdata_zero_q;

  logic [29:0]      f_word, l_word;
  logic [IDX_W-1:0] f_idx, l_idx, ram_idx;
  logic             f_bad, l_bad;
  logic             force_f;
  logic             ram_we, ram_re;
  logic [31:0]      ram_rdata;

  assign f_word = im_idx(f_addr);
  assign l_word = im_idx(l_addr);
  assign f_idx  = f_word[IDX_W-1:0];
  assign l_idx  = l_word[IDX_W-1:0];

`ifdef IM_ARB_BOUNDS_EN
  assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr >= 32'(4 * DEPTH));
  assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr >= 32'(4 * DEPTH));
`else
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif

  // Address bits beyond the index only matter for the bounds check.
  logic unused_ok;
  assign unused_ok = ^{f_addr[1:0], l_addr[1:0], f_word, l_word};

  // Fetch is forced through once it has been denied STARVE_MAX times in a row.
  assign force_f = (starve_q == SW'(STARVE_MAX)) && f_req;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    unique case (state_q)
      LOAD: begin
        l_gnt    = l_req;
        starve_d = '0;
        if (l_done) state_d = RUN;
      end
      RUN: begin
        f_gnt = f_req & (force_f | ~l_req);
        l_gnt = l_req & ~force_f;
        if (f_gnt || !f_req)      starve_d = '0;
        else if (l_gnt && starve_q != SW'(STARVE_MAX))
                                  starve_d = starve_q + SW'(1);
      end
      default: state_d = LOAD;
    endcase
    // No grant is offered while reset is asserted, so nothing reaches memory.
    if (!rst_n) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      starve_q     <= '0;
      f_rvalid_q   <= 1'b0;
      f_err_q      <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      f_rvalid_q <= f_gnt;
      f_err_q    <= f_gnt & f_bad;
      // The RAM read register has no reset; this flag forces f_rdata to 0
      // until a good read has landed, and again after a bad read.
      if (f_gnt) rdata_zero_q <= f_bad;
    end
  end

  assign ram_we  = l_gnt & ~l_bad;
  assign ram_re  = f_gnt & ~f_bad;
  assign ram_idx = l_gnt ? l_idx : f_idx;

  im_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (ram_idx),
    .wdata_i (l_wdata),
    .rdata_o (ram_rdata)
  );

  assign f_rvalid  = f_rvalid_q;
  assign f_rdata   = rdata_zero_q ? 32'h0 : ram_rdata;
  assign f_err     = f_err_q;
  assign l_err     = l_gnt & l_bad;
  assign running   = (state_q == RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_im_arbiter.sv
module tb_im_arbiter;
  import im_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        l_req = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_gnt;
  logic        l_err;
  logic        l_done = 1'b0;
  logic        running;
  im_state_e   dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic [31:0] model_mem [64];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  im_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_err(l_err), .l_done(l_done),
    .running(running), .dbg_state(dbg_state)
  );

  // ---------------- reference helpers ----------------
  function automatic logic bad_addr(input logic [31:0] a);
`ifdef IM_ARB_BOUNDS_EN
    return (a[1:0] != 2'b00) || (a >= 32'd256);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered just after a rising edge. Drives requests, checks the
  // combinational grants mid-cycle, updates the model, then checks the
  // registered response just after the next edge.
  task automatic cycle(input string tag,
                       input logic fr, input logic [31:0] fa,
                       input logic lr, input logic [31:0] la, input logic [31:0] lw,
                       input logic ld, input logic exp_fg, input logic exp_lg);
    logic [31:0] e;
    logic        ee;
    f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = lw; l_done = ld;
    #4;
    check({tag, ".f_gnt"}, 32'(f_gnt), 32'(exp_fg));
    check({tag, ".l_gnt"}, 32'(l_gnt), 32'(exp_lg));
    if (exp_lg) check({tag, ".l_err"}, 32'(l_err), 32'(bad_addr(la)));
    if (exp_fg) begin
      exp_q.push_back(bad_addr(fa) ? 32'h0 : model_mem[widx(fa)]);
      err_q.push_back(bad_addr(fa));
    end
    if (exp_lg && !bad_addr(la)) model_mem[widx(la)] = lw;
    @(posedge clk); #1;
    check({tag, ".f_rvalid"}, 32'(f_rvalid), 32'(exp_fg));
    if (exp_fg) begin
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ee = err_q.pop_front();
        check({tag, ".f_rdata"}, f_rdata, e);
        check({tag, ".f_err"}, 32'(f_err), 32'(ee));
      end
    end
    f_req = 1'b0; l_req = 1'b0; l_done = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.f_rvalid", 32'(f_rvalid), 32'h0);
    check("rst.f_rdata", f_rdata, 32'h0);
    check("rst.f_err", 32'(f_err), 32'h0);
    check("rst.running", 32'(running), 32'h0);
    check("rst.state", 32'(dbg_state), 32'(LOAD));
    rst_n = 1'b1;

    // Fetch held off while loading
    for (int i = 0; i < 10; i++) begin
      cycle("hold", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("hold.running", 32'(running), 32'h0);
    end

    // Load two words; the write in the l_done cycle still lands
    cycle("load0", 1'b0, 32'h0, 1'b1, 32'h0, 32'h20080020, 1'b0, 1'b0, 1'b1);
    check("load0.running", 32'(running), 32'h0);
    cycle("load1", 1'b0, 32'h0, 1'b1, 32'h4, 32'h20090037, 1'b1, 1'b0, 1'b1);
    check("load1.running", 32'(running), 32'h1);
    check("load1.state", 32'(dbg_state), 32'(RUN));

    // Back-to-back fetch of the loaded words
    cycle("rd0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("rd0.word", f_rdata, 32'h20080020);
    cycle("rd1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("rd1.word", f_rdata, 32'h20090037);
    cycle("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("idle.hold", f_rdata, 32'h20090037);

    // Starvation: 4 denied cycles, fetch forced on the 5th, loader back on 6th
    for (int i = 0; i < 4; i++)
      cycle("starve.deny", 1'b1, 32'h0, 1'b1, 32'h40 + 32'(4 * i),
            $urandom_range(32'hFFFF, 1), 1'b0, 1'b0, 1'b1);
    cycle("starve.force", 1'b1, 32'h40, 1'b1, 32'h50, 32'h5A5A0001, 1'b0, 1'b1, 1'b0);
    cycle("starve.back", 1'b1, 32'h4, 1'b1, 32'h50, 32'h5A5A0001, 1'b0, 1'b0, 1'b1);
    cycle("starve.read", 1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Write then immediate read of the same word
    cycle("raw.wr", 1'b0, 32'h0, 1'b1, 32'h3C, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    cycle("raw.rd", 1'b1, 32'h3C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("raw.word", f_rdata, 32'hDEADBEEF);

    // Address boundary behaviour
`ifdef IM_ARB_BOUNDS_EN
    cycle("bnd.rd", 1'b1, 32'h102, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("bnd.rd.err", 32'(f_err), 32'h1);
    check("bnd.rd.data", f_rdata, 32'h0);
    cycle("bnd.wr", 1'b0, 32'h0, 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 1'b1);
    cycle("bnd.chk", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("bnd.word0", f_rdata, 32'h20080020);
    model_mem[0] = 32'h20080020;
`else
    cycle("wrap.wr", 1'b0, 32'h0, 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 1'b1);
    check("wrap.l_err", 32'(l_err), 32'h0);
    cycle("wrap.chk", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("wrap.word0", f_rdata, 32'h12345678);
`endif

    // Reset in the cycle after a read grant
    f_req = 1'b1; f_addr = 32'h4;
    #4;
    check("mrst.f_gnt", 32'(f_gnt), 32'h1);
    @(posedge clk); #1;
    f_req = 1'b0;
    rst_n = 1'b0;
    l_req = 1'b1; l_addr = 32'h4; l_wdata = 32'hBAD0BAD0;
    #1;
    check("mrst.f_rvalid", 32'(f_rvalid), 32'h0);
    check("mrst.running", 32'(running), 32'h0);
    check("mrst.state", 32'(dbg_state), 32'(LOAD));
    check("mrst.l_gnt", 32'(l_gnt), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    l_req = 1'b0;
    rst_n = 1'b1;
    check("mrst.f_rdata", f_rdata, 32'h0);
    cycle("mrst.done", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("mrst.running2", 32'(running), 32'h1);
    cycle("mrst.rd0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("mrst.rd1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("mrst.word1", f_rdata, 32'h20090037);
    cycle("mrst.rd3c", 1'b1, 32'h3C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // ---------------- final report ----------------
    check("sb.empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
